// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared cache-side types: line/beat widths, line offset, adaptor state enum
package cache_types;

  localparam int unsigned LINE_W_DEF    = 256;
  localparam int unsigned BURST_W_DEF   = 64;
  localparam int unsigned LINE_OFFSET_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// rtl/line_beat_buffer.sv - line register with whole-line load, beat-indexed fill and beat-indexed select
module line_beat_buffer #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  localparam int unsigned BEATS  = LINE_W / BURST_W,
  localparam int unsigned IDX_W  = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [LINE_W-1:0]  load_data_i,
  input  logic               beat_we_i,
  input  logic [IDX_W-1:0]   beat_idx_i,
  input  logic [BURST_W-1:0] beat_data_i,
  output logic [LINE_W-1:0]  line_o,
  output logic [BURST_W-1:0] beat_o
);

  logic [LINE_W-1:0] buf_q, buf_d;

  // Whole-line load takes priority over a single beat write
  always_comb begin
    buf_d = buf_q;
    if (load_i) begin
      buf_d = load_data_i;
    end else if (beat_we_i) begin
      buf_d[beat_idx_i*BURST_W +: BURST_W] = beat_data_i;
    end
  end

  // Line storage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_q <= '0;
    else        buf_q <= buf_d;
  end

  assign line_o = buf_q;
  assign beat_o = buf_q[beat_idx_i*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit line request to 4-beat 64-bit burst adaptor; CACHELINE_ADAPTOR_STATS_EN adds stat_reads/stat_writes
module cacheline_adaptor
  import cache_types::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  line_address,
  output logic [LINE_W-1:0]  line_rdata,
  input  logic [LINE_W-1:0]  line_wdata,
  input  logic               line_read,
  input  logic               line_write,
  output logic               line_resp,
  output logic [ADDR_W-1:0]  burst_address,
  input  logic [BURST_W-1:0] burst_rdata,
  output logic [BURST_W-1:0] burst_wdata,
  output logic               burst_read,
  output logic               burst_write,
  input  logic               burst_resp
`ifdef CACHELINE_ADAPTOR_STATS_EN
  ,
  output logic [31:0]        stat_reads,
  output logic [31:0]        stat_writes
`endif
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = $clog2(BEATS);

  adaptor_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_load, rd_fill, last_beat;
  logic [ADDR_W-1:0] aligned_addr;
  logic [BURST_W-1:0] wr_beat;
  logic [BURST_W-1:0] rbuf_beat_unused;
  logic [LINE_W-1:0]  wbuf_line_unused;
  logic [LINE_OFFSET_W-1:0] addr_offset_unused;

  assign aligned_addr       = {line_address[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  assign addr_offset_unused = line_address[LINE_OFFSET_W-1:0];
  assign last_beat          = (cnt_q == CNT_W'(BEATS - 1));

  // Next-state, beat counter and latch strobes; write wins over read in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_load = 1'b0;
    rd_fill = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (line_write) begin
          addr_d  = aligned_addr;
          wr_load = 1'b1;
          state_d = S_WRITE;
        end else if (line_read) begin
          addr_d  = aligned_addr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (burst_resp) begin
          rd_fill = 1'b1;
          if (last_beat) state_d = S_DONE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (burst_resp) begin
          if (last_beat) state_d = S_DONE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and burst address registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Read fill buffer is separate so a write cannot disturb the last read line
  line_beat_buffer #(.LINE_W(LINE_W), .BURST_W(BURST_W)) u_rbuf (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .beat_we_i   (rd_fill),
    .beat_idx_i  (cnt_q),
    .beat_data_i (burst_rdata),
    .line_o      (line_rdata),
    .beat_o      (rbuf_beat_unused)
  );

  line_beat_buffer #(.LINE_W(LINE_W), .BURST_W(BURST_W)) u_wbuf (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (wr_load),
    .load_data_i (line_wdata),
    .beat_we_i   (1'b0),
    .beat_idx_i  (cnt_q),
    .beat_data_i ('0),
    .line_o      (wbuf_line_unused),
    .beat_o      (wr_beat)
  );

  assign burst_address = addr_q;
  assign burst_read    = (state_q == S_READ);
  assign burst_write   = (state_q == S_WRITE);
  assign burst_wdata   = (state_q == S_WRITE) ? wr_beat : '0;
  assign line_resp     = (state_q == S_DONE);

`ifdef CACHELINE_ADAPTOR_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d;

  // Saturating completion counters, bumped on entry to DONE
  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    if (state_q == S_READ && burst_resp && last_beat && stat_reads_q != 32'hFFFF_FFFF)
      stat_reads_d = stat_reads_q + 32'd1;
    if (state_q == S_WRITE && burst_resp && last_beat && stat_writes_q != 32'hFFFF_FFFF)
      stat_writes_d = stat_writes_q + 32'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule
